// File: rtl/aes_if_pkg.sv
// aes_if_pkg: shared command/state encodings and block geometry for the AES input interface
package aes_if_pkg;
  localparam int BLOCK_BYTES = 16;
  localparam int DIN_W = 8;
  localparam int BLOCK_W = BLOCK_BYTES * DIN_W;
  localparam int CNT_W = 5;
  typedef enum logic [1:0] {
    CMD_ID = 2'b00,
    CMD_SP = 2'b01,
    CMD_SK = 2'b10,
    CMD_ST = 2'b11
  } cmd_e;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_P,
    S_LOAD_K,
    S_BUSY,
    S_HOLD
  } state_e;
endpackage

// File: rtl/byte_block_loader.sv
// byte_block_loader: 128-bit byte shift buffer with a saturating byte counter
module byte_block_loader
  import aes_if_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic [DIN_W-1:0]   din,
  output logic [BLOCK_W-1:0] data
);
  logic [CNT_W-1:0] cnt_q, cnt_d, base;
  logic [BLOCK_W-1:0] data_q, data_d;
  logic take;
  // clr restarts the burst before the current byte is counted; a full burst ignores further bytes
  always_comb begin
    base = clr ? '0 : cnt_q;
    take = en && (base < CNT_W'(BLOCK_BYTES));
    data_d = take ? {data_q[BLOCK_W-DIN_W-1:0], din} : data_q;
    cnt_d = take ? base + CNT_W'(1) : base;
  end
  // buffer and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      data_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      data_q <= data_d;
    end
  end
  assign data = data_q;
endmodule

// File: rtl/input_interface.sv
// input_interface: byte-serial plaintext/key collector and start handshake for the AES engine
module input_interface
  import aes_if_pkg::*;
(
  input  logic               clk,
  input  logic               rst_,
  input  logic [DIN_W-1:0]   din,
  input  logic [1:0]         cmd,
  output logic               ready,
  input  logic               transformer_done,
  output logic               key_start,
  output logic [BLOCK_W-1:0] plain_out,
  output logic [BLOCK_W-1:0] key_out
);
  cmd_e c;
  state_e state_q, state_d;
  logic accept, start;
  logic key_start_q, key_start_d;
  logic [BLOCK_W-1:0] plain_q, plain_d, key_q, key_d, pbuf, kbuf;
  assign c = cmd_e'(cmd);
  // HOLD behaves as IDLE as soon as the held start command is released
  assign accept = (state_q inside {S_IDLE, S_LOAD_P, S_LOAD_K}) || (state_q == S_HOLD && c != CMD_ST);
  assign start = accept && c == CMD_ST;
  byte_block_loader u_pbuf (
    .clk (clk),
    .rst (rst_),
    .en  (accept && c == CMD_SP),
    .clr (!(state_q == S_LOAD_P && c == CMD_SP)),
    .din (din),
    .data(pbuf)
  );
  byte_block_loader u_kbuf (
    .clk (clk),
    .rst (rst_),
    .en  (accept && c == CMD_SK),
    .clr (!(state_q == S_LOAD_K && c == CMD_SK)),
    .din (din),
    .data(kbuf)
  );
  // state register
  always_ff @(posedge clk) begin
    if (rst_) state_q <= S_IDLE;
    else state_q <= state_d;
  end
  // next state; key_start_q marks the first BUSY cycle, where done is ignored
  always_comb begin
    state_d = state_q;
    if (accept) state_d = c == CMD_SP ? S_LOAD_P : c == CMD_SK ? S_LOAD_K : c == CMD_ST ? S_BUSY : S_IDLE;
    else if (state_q == S_BUSY && !key_start_q && transformer_done) state_d = S_HOLD;
  end
  // output next values: commit buffers and pulse key_start on an accepted start
  always_comb begin
    key_start_d = start;
    plain_d = start ? pbuf : plain_q;
    key_d = start ? kbuf : key_q;
  end
  // output registers
  always_ff @(posedge clk) begin
    if (rst_) begin
      key_start_q <= 1'b0;
      plain_q <= '0;
      key_q <= '0;
    end else begin
      key_start_q <= key_start_d;
      plain_q <= plain_d;
      key_q <= key_d;
    end
  end
  assign ready = state_q != S_BUSY;
  assign key_start = key_start_q;
  assign plain_out = plain_q;
  assign key_out = key_q;
endmodule

// File: tb/tb_input_interface.sv
// tb_input_interface: randomized and directed checks of input_interface against a behavioural model
module tb_input_interface;
  logic clk = 0;
  logic rst_;
  logic [7:0] din;
  logic [1:0] cmd;
  logic transformer_done;
  logic ready, key_start;
  logic [127:0] plain_out, key_out;

  localparam logic [1:0] ID = 2'b00, SP = 2'b01, SK = 2'b10, ST = 2'b11;

  input_interface dut (
    .clk             (clk),
    .rst_            (rst_),
    .din             (din),
    .cmd             (cmd),
    .ready           (ready),
    .transformer_done(transformer_done),
    .key_start       (key_start),
    .plain_out       (plain_out),
    .key_out         (key_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask

  // behavioural model: byte lists, burst run lengths, busy age
  bit armed = 0;
  bit [127:0] m_p, m_k, m_po, m_ko;
  int prun, krun, age;
  bit busy, waiting, ks;

  always @(posedge clk) begin
    if (rst_) begin
      m_p = 0; m_k = 0; m_po = 0; m_ko = 0;
      prun = 0; krun = 0; age = 0;
      busy = 0; waiting = 0; ks = 0;
      armed = 1;
    end else begin
      ks = 0;
      if (busy) begin
        prun = 0; krun = 0;
        if (age > 0 && transformer_done) begin
          busy = 0;
          waiting = 1;
        end else age++;
      end else if (waiting && cmd == ST) begin
        prun = 0; krun = 0;
      end else begin
        waiting = 0;
        if (cmd == SP) begin
          if (prun < 16) m_p = {m_p[119:0], din};
          prun++;
          krun = 0;
        end else if (cmd == SK) begin
          if (krun < 16) m_k = {m_k[119:0], din};
          krun++;
          prun = 0;
        end else if (cmd == ST) begin
          m_po = m_p; m_ko = m_k;
          ks = 1; busy = 1; age = 0;
          prun = 0; krun = 0;
        end else begin
          prun = 0; krun = 0;
        end
      end
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (armed) begin
      chk("ready", 128'(ready), 128'(!busy));
      chk("key_start", 128'(key_start), 128'(ks));
      chk("plain_out", plain_out, m_po);
      chk("key_out", key_out, m_ko);
    end
  end

  task automatic cyc(input logic [1:0] c, input logic [7:0] d, input logic dn, input logic r = 1'b0);
    rst_ = r; cmd = c; din = d; transformer_done = dn;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(ID, 8'h00, 1'b1);
  endtask

  logic [7:0] pb [16];
  logic [7:0] kb [16];
  logic [7:0] bb [20];
  logic [127:0] exp_v, prev_p, prev_k;
  int np;

  initial begin
    pb = '{8'h00, 8'h04, 8'h12, 8'h14, 8'h12, 8'h04, 8'h12, 8'h00, 8'h0C, 8'h00, 8'h13, 8'h11, 8'h08, 8'h23, 8'h19, 8'h19};
    kb = '{8'h24, 8'h75, 8'hA2, 8'hB3, 8'h34, 8'h75, 8'h56, 8'h88, 8'h31, 8'hE2, 8'h12, 8'h00, 8'h13, 8'hAA, 8'h54, 8'h87};
    rst_ = 1; cmd = ID; din = 0; transformer_done = 1;
    @(negedge clk);
    chk("rst_ready", 128'(ready), 128'(1));
    chk("rst_key_start", 128'(key_start), 128'(0));
    chk("rst_plain", plain_out, 128'h0);
    chk("rst_key", key_out, 128'h0);

    for (int i = 0; i < 16; i++) cyc(SP, pb[i], 1'b1);
    cyc(ID, 8'h00, 1'b1);
    cyc(ST, 8'h00, 1'b1);
    chk("pt_load", plain_out, 128'h00041214120412000C00131108231919);
    chk("pt_pulse", 128'(key_start), 128'(1));
    chk("pt_ready", 128'(ready), 128'(0));
    idle(3);

    for (int i = 0; i < 16; i++) cyc(SK, kb[i], 1'b1);
    cyc(ID, 8'h00, 1'b1);
    cyc(ST, 8'h00, 1'b0);
    chk("key_load", key_out, 128'h2475A2B33475568831E2120013AA5487);
    chk("key_pt_kept", plain_out, 128'h00041214120412000C00131108231919);
    cyc(ID, 8'h00, 1'b0);
    cyc(ID, 8'h00, 1'b0);
    chk("key_busy_ready", 128'(ready), 128'(0));
    idle(3);

    np = 0;
    for (int i = 0; i < 9; i++) begin
      cyc(ST, 8'h00, i >= 8);
      if (key_start === 1'b1) np++;
      if (i == 7) chk("hs_ready_low", 128'(ready), 128'(0));
    end
    chk("hs_ready_back", 128'(ready), 128'(1));
    for (int i = 0; i < 3; i++) begin
      cyc(ST, 8'h00, 1'b1);
      if (key_start === 1'b1) np++;
    end
    chk("hs_one_pulse", 128'(np), 128'(1));
    cyc(ID, 8'h00, 1'b1);
    cyc(ST, 8'h00, 1'b1);
    chk("hs_repulse", 128'(key_start), 128'(1));
    idle(3);

    for (int i = 0; i < 20; i++) bb[i] = 8'($urandom);
    exp_v = 0;
    for (int i = 0; i < 16; i++) exp_v = {exp_v[119:0], bb[i]};
    for (int i = 0; i < 20; i++) cyc(SP, bb[i], 1'b1);
    cyc(ID, 8'h00, 1'b1);
    cyc(ST, 8'h00, 1'b1);
    chk("sat16", plain_out, exp_v);
    idle(3);

    for (int i = 0; i < 8; i++) bb[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) exp_v = {exp_v[119:0], bb[i]};
    for (int i = 0; i < 5; i++) cyc(SP, bb[i], 1'b1);
    cyc(ID, 8'h00, 1'b1);
    for (int i = 5; i < 8; i++) cyc(SP, bb[i], 1'b1);
    cyc(ID, 8'h00, 1'b1);
    cyc(ST, 8'h00, 1'b1);
    chk("partial", plain_out, exp_v);
    idle(3);

    prev_p = plain_out;
    prev_k = key_out;
    cyc(ST, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) cyc(i[0] ? SK : SP, 8'($urandom), 1'b0);
    chk("busy_pt_stable", plain_out, prev_p);
    idle(3);
    cyc(ST, 8'h00, 1'b1);
    chk("busy_pbuf_kept", plain_out, prev_p);
    chk("busy_kbuf_kept", key_out, prev_k);
    idle(3);

    cyc(SP, 8'hAB, 1'b1);
    cyc(ST, 8'h00, 1'b0);
    cyc(ID, 8'h00, 1'b0, 1'b1);
    chk("mid_rst_ready", 128'(ready), 128'(1));
    chk("mid_rst_ks", 128'(key_start), 128'(0));
    chk("mid_rst_plain", plain_out, 128'h0);
    chk("mid_rst_key", key_out, 128'h0);
    cyc(ST, 8'h00, 1'b0);
    chk("mid_rst_restart", 128'(key_start), 128'(1));
    idle(3);

    for (int i = 0; i < 4000; i++) begin
      int w;
      logic [1:0] c;
      w = $urandom_range(0, 9);
      c = w < 4 ? SP : w < 7 ? SK : w < 8 ? ST : ID;
      cyc(c, 8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 299) == 0);
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/input_interface.md
Name: input_interface

Overview:
Byte-serial front end of the AES engine. Collects a 128-bit plaintext and a 128-bit key one byte per clock under a 2-bit command. On a start command it presents both blocks to the AES transformer and issues a one-cycle key_start. It then holds off new input until the transformer reports done.

Parameters:
BLOCK_BYTES, 16, bytes per plaintext/key block (fixed; other values unsupported)
DIN_W, 8, width of din in bits

Ports:
clk  in  1  rising-edge clock
rst_  in  1  synchronous reset, active-high
din  in  8  input byte, sampled every rising edge while loading
cmd  in  2  command: 00 ID idle, 01 SP set plaintext, 10 SK set key, 11 ST start
ready  out  1  high = interface accepts commands; low = encryption in progress
transformer_done  in  1  AES engine done/idle status
key_start  out  1  one-cycle start pulse to the AES engine
plain_out  out  128  committed plaintext to engine; first loaded byte in [127:120]
key_out  out  128  committed key to engine; first loaded byte in [127:120]

Behaviour:
- Reset (rst_=1 at a rising edge) clears:
  - state=IDLE, byte counter=0, both shift buffers=0
  - plain_out=0, key_out=0, key_start=0, ready=1
- States: IDLE, LOAD_P, LOAD_K, BUSY, HOLD. All transitions are registered.
- IDLE/LOAD_P/LOAD_K, by cmd at each edge:
  - cmd=SP: pbuf<={pbuf[119:0],din}, counter++ → LOAD_P.
  - cmd=SK: same on kbuf → LOAD_K.
  - cmd=ID: → IDLE, counter<=0.
- The first edge after any change of cmd value resets the counter before counting the captured byte, so every SP/SK burst starts at byte 0.
- Counter saturates at 16: a 17th+ consecutive byte in one burst is ignored and the buffer is unchanged.
- A partial burst (<16 bytes) leaves the captured bytes shifted in. Untouched bytes keep their old values.
- Going SP→SK directly is legal and starts a fresh key burst.
- cmd=ST in IDLE/LOAD_P/LOAD_K is accepted regardless of transformer_done. At that edge:
  - plain_out<=pbuf, key_out<=kbuf
  - key_start<=1, ready<=0
  - state<=BUSY
- BUSY:
  - key_start drops to 0 on the next edge (exactly one-cycle pulse).
  - transformer_done is ignored in the first BUSY cycle.
  - From the second BUSY cycle on, transformer_done=1 at an edge → HOLD, ready<=1.
- HOLD: waits for cmd≠ST, then behaves as IDLE for that same edge (SP/SK bytes are captured). ST held continuously never retriggers.
- During BUSY all cmd/din are ignored. Buffers and plain_out/key_out stay stable.
- Outputs plain_out/key_out change only on ST acceptance or reset.
- ST with nothing loaded commits the current buffers (zeros after reset).
- Reset mid-load or mid-BUSY aborts immediately and all registers return to reset values. The pending key_start is cleared.

Decomposition:
- Shared package aes_if_pkg holds:
  - cmd encodings CMD_ID/CMD_SP/CMD_SK/CMD_ST
  - state encoding
  - BLOCK_BYTES=16, BLOCK_W=128
- One natural sub-module: byte_block_loader (128-bit shift buffer + saturating 5-bit counter, enable/clear inputs). It is instanced twice, for plaintext and key.
- The FSM and output registers stay in input_interface.

Test Plan:
- Reset: rst_=1 for one edge → ready=1, key_start=0, plain_out=0, key_out=0.
- Plaintext load: SP with bytes 00 04 12 14 12 04 12 00 0C 00 13 11 08 23 19 19, then ID, then ST → plain_out=128'h00041214120412000C00131108231919 on the ST edge.
- Key load: SK with bytes 24 75 A2 B3 34 75 56 88 31 E2 12 00 13 AA 54 87, then ID, then ST (transformer_done=0 with ST) → key_out=128'h2475A2B33475568831E2120013AA5487.
- Start handshake: ST held 9 cycles, transformer_done returns to 1 after 8 → exactly one key_start pulse. ready low from the cycle after ST acceptance until the edge after done=1. No second pulse while ST remains high; after ID, a new ST re-pulses.
- Boundaries:
  - 20 SP bytes → only the first 16 are stored.
  - 5 SP bytes, ID, 3 SP bytes → counter restarted; buffer holds the latest 8 bytes shifted in.
  - SP/SK bytes driven during BUSY → no change in plain_out, key_out or the buffers.
- Reset mid-BUSY: assert rst_ one cycle after ST → ready=1, key_start=0, outputs zero; ST then accepted normally.
